// File: rtl/key_reverse_lookup.sv
// Reverse lookup over a MuxKey-format key/data table: scans one entry per clock and
// returns the first key whose data matches. Optional miss key: KEY_REVERSE_LOOKUP_DEFAULT_EN.
module key_reverse_lookup #(
    parameter  int NR_KEY   = 2,
    parameter  int KEY_LEN  = 1,
    parameter  int DATA_LEN = 1,
    localparam int IDX_LEN  = (NR_KEY > 1) ? $clog2(NR_KEY) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [DATA_LEN-1:0]                  data_in,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
`ifdef KEY_REVERSE_LOOKUP_DEFAULT_EN
    input  logic [KEY_LEN-1:0]                   default_key,
`endif
    output logic                                 busy,
    output logic                                 done,
    output logic                                 found,
    output logic [KEY_LEN-1:0]                   key_out,
    output logic [IDX_LEN-1:0]                   index_out
);

    localparam int                 ENTRY_W  = KEY_LEN + DATA_LEN;
    localparam logic [IDX_LEN-1:0] LAST_IDX = IDX_LEN'(NR_KEY - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t                             state;
    logic [IDX_LEN-1:0]                 idx;
    logic [DATA_LEN-1:0]                data_q;
    logic [NR_KEY*ENTRY_W-1:0]          lut_q;
    logic [ENTRY_W-1:0]                 cur_entry;
    logic [KEY_LEN-1:0]                 cur_key;
    logic [DATA_LEN-1:0]                cur_data;
    logic [KEY_LEN-1:0]                 miss_key;

    assign cur_entry = lut_q[int'(idx) * ENTRY_W +: ENTRY_W];
    assign cur_key   = cur_entry[ENTRY_W-1 -: KEY_LEN];
    assign cur_data  = cur_entry[DATA_LEN-1:0];

`ifdef KEY_REVERSE_LOOKUP_DEFAULT_EN
    assign miss_key = default_key;
`else
    assign miss_key = '0;
`endif

    // busy is the state register itself, so it stays a registered output.
    assign busy = (state == SCAN);

    // NOTE: the search snapshot is pure datapath and is only read while SCAN, which
    // reset leaves; it therefore needs no reset and keeps the wide table out of the reset tree.
    always_ff @(posedge clk) begin
        if (!busy && start) begin
            data_q <= data_in;
            lut_q  <= lut;
        end
    end

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            done      <= 1'b0;
            found     <= 1'b0;
            key_out   <= '0;
            index_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx   <= '0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_data == data_q) begin
                        found     <= 1'b1;
                        key_out   <= cur_key;
                        index_out <= idx;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        found     <= 1'b0;
                        key_out   <= miss_key;
                        index_out <= '0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        idx <= idx + IDX_LEN'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_reverse_lookup.sv
// Scoreboard bench for key_reverse_lookup: stimulus pushes model results into a queue,
// a negedge monitor pops and compares on every done pulse and checks holding outputs otherwise.
module tb_key_reverse_lookup;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 3;
    localparam int DATA_LEN = 8;
    localparam int IDX_LEN  = 2;
    localparam int ENTRY_W  = KEY_LEN + DATA_LEN;

    typedef struct {
        logic               found;
        logic [KEY_LEN-1:0] key;
        logic [IDX_LEN-1:0] index;
        int                 latency;
        int                 start_cyc;
    } exp_t;

    logic                         clk = 1'b0;
    logic                         rst = 1'b1;
    logic                         start = 1'b0;
    logic [DATA_LEN-1:0]          data_in = '0;
    logic [NR_KEY*ENTRY_W-1:0]    lut = '0;
    logic [KEY_LEN-1:0]           default_key = 3'd6;
    logic                         busy, done, found;
    logic [KEY_LEN-1:0]           key_out;
    logic [IDX_LEN-1:0]           index_out;

    logic [KEY_LEN-1:0]           keys  [NR_KEY];
    logic [DATA_LEN-1:0]          datas [NR_KEY];
    exp_t                         sb_q[$];
    logic                         hold_found = 1'b0;
    logic [KEY_LEN-1:0]           hold_key = '0;
    logic [IDX_LEN-1:0]           hold_index = '0;
    int                           cyc = 0;
    int                           n_checks = 0;
    int                           n_fail = 0;

    key_reverse_lookup #(.NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN)) dut (
        .clk(clk), .rst(rst), .start(start), .data_in(data_in), .lut(lut),
`ifdef KEY_REVERSE_LOOKUP_DEFAULT_EN
        .default_key(default_key),
`endif
        .busy(busy), .done(done), .found(found), .key_out(key_out), .index_out(index_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [KEY_LEN-1:0] miss_key();
`ifdef KEY_REVERSE_LOOKUP_DEFAULT_EN
        return default_key;
`else
        return '0;
`endif
    endfunction

    // Reference: first table entry whose data equals d; miss costs a full scan.
    function automatic exp_t model(input logic [DATA_LEN-1:0] d);
        exp_t e;
        e.found = 1'b0; e.key = miss_key(); e.index = '0; e.latency = NR_KEY; e.start_cyc = 0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (!e.found && datas[i] == d) begin
                e.found = 1'b1; e.key = keys[i]; e.index = IDX_LEN'(i); e.latency = i + 1;
            end
        end
        return e;
    endfunction

    task automatic pack_lut();
        for (int i = 0; i < NR_KEY; i++) lut[i*ENTRY_W +: ENTRY_W] = {keys[i], datas[i]};
    endtask

    // Called at posedge+#1 while the DUT is idle or in its done cycle.
    task automatic issue(input logic [DATA_LEN-1:0] d);
        exp_t e;
        data_in = d;
        start   = 1'b1;
        e = model(d);
        @(posedge clk);
        #1;
        start = 1'b0;
        e.start_cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done) return;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare on done, otherwise results must hold and busy must track in-flight work.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", busy, (sb_q.size() > 0) && !done);
                if (done) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", done, 1'b0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        check("found", found, e.found);
                        check("key_out", key_out, e.key);
                        check("index_out", index_out, e.index);
                        check("latency", cyc - e.start_cyc, e.latency);
                        hold_found = e.found; hold_key = e.key; hold_index = e.index;
                    end
                end else begin
                    check("hold_found", found, hold_found);
                    check("hold_key", key_out, hold_key);
                    check("hold_index", index_out, hold_index);
                end
            end
        end
    end

    initial begin
        keys[0] = 3'd5; datas[0] = 8'h41;
        keys[1] = 3'd2; datas[1] = 8'h10;
        keys[2] = 3'd7; datas[2] = 8'h41;
        keys[3] = 3'd1; datas[3] = 8'hFF;
        pack_lut();

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_found", found, 1'b0);
        check("rst_key", key_out, 3'd0);
        check("rst_index", index_out, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        issue(8'h41); wait_done(); idle_cycles(2);
        issue(8'hFF); wait_done(); idle_cycles(2);
        issue(8'h00); wait_done(); idle_cycles(2);

        // Reset in the middle of a scan discards the search.
        issue(8'hFF);
        idle_cycles(1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_found", found, 1'b0);
        check("midrst_key", key_out, 3'd0);
        check("midrst_index", index_out, 2'd0);
        sb_q.delete();
        hold_found = 1'b0; hold_key = '0; hold_index = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(6);
        issue(8'h10); wait_done(); idle_cycles(2);

        // start and table changes during a scan are ignored.
        issue(8'hFF);
        data_in = 8'h10;
        start   = 1'b1;
        lut     = ~lut;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done();
        pack_lut();
        idle_cycles(2);

        // Back-to-back: new start in the done cycle.
        issue(8'h10); wait_done();
        issue(8'h41); wait_done(); idle_cycles(3);

        // Randomized tables and searches with small data alphabet for duplicates and misses.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR_KEY; i++) begin
                keys[i]  = KEY_LEN'($urandom);
                datas[i] = DATA_LEN'($urandom_range(0, 5));
            end
            default_key = KEY_LEN'($urandom);
            pack_lut();
            issue(DATA_LEN'($urandom_range(0, 7)));
            wait_done();
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        check("queue_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
